// File: rtl/banked_mem_resp_pkg.sv
// banked_mem_resp_pkg: shared constants and types for the four-bank memory responder.
package banked_mem_resp_pkg;
    localparam int NUM_BANKS = 4;
    localparam int BANK_LSB  = 1;
    localparam int BANK_MSB  = 2;
    localparam int BANK_W    = BANK_MSB - BANK_LSB + 1;
    localparam int IDX_LSB   = BANK_MSB + 1;
    localparam int WORD_W    = 16;
    localparam int RD_LAT    = 2;

    typedef struct packed {
        logic              v;
        logic [BANK_W-1:0] bank;
    } ret_t;
endpackage

// File: rtl/banked_mem_resp_mem_bank.sv
// mem_bank: one word-wide memory bank with busy down-counter and read-capture register.
module mem_bank
    import banked_mem_resp_pkg::*;
#(
    parameter int BANK_CYCLES = 2,
    parameter int BANK_AW     = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc,
    input  logic               we,
    input  logic [BANK_AW-1:0] idx,
    input  logic [WORD_W-1:0]  wdata,
    output logic               busy,
    output logic [WORD_W-1:0]  rdata
);
    localparam int CW = $clog2(BANK_CYCLES);

    logic [CW-1:0]     cnt_q;
    logic [WORD_W-1:0] mem_q [2**BANK_AW];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (acc) cnt_q <= CW'(BANK_CYCLES - 1);
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    // Array contents survive reset, so this block has no reset term.
    always_ff @(posedge clk) begin
        if (acc && we) mem_q[idx] <= wdata;
        if (acc && !we) rdata_q <= mem_q[idx];
    end

    assign busy  = |cnt_q;
    assign rdata = rdata_q;
endmodule

// File: rtl/banked_mem_resp.sv
// banked_mem_resp: four-bank interleaved memory responder with fixed 2-cycle read return.
module banked_mem_resp
    import banked_mem_resp_pkg::*;
#(
    parameter int BANK_CYCLES = 2,
    parameter int BANK_AW     = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          addr,
    input  logic [WORD_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [WORD_W-1:0]    data_out,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);
    logic [BANK_W-1:0] bank;
    logic              req;
    logic              bad;
    logic              acc;
    logic [WORD_W-1:0] rdata [NUM_BANKS];
    ret_t              ret_d, ret_q;
    logic [WORD_W-1:0] data_out_d, data_out_q;
    logic              err_q;

    assign bank = addr[BANK_MSB:BANK_LSB];
    assign req  = (wr ^ rd) & ~addr[0];
    assign bad  = (wr & rd) | ((wr | rd) & addr[0]);
    assign acc  = req & ~busy[bank];

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            mem_bank #(
                .BANK_CYCLES(BANK_CYCLES),
                .BANK_AW    (BANK_AW)
            ) u_bank (
                .clk  (clk),
                .rst  (rst),
                .acc  (acc && bank == BANK_W'(b)),
                .we   (wr),
                .idx  (addr[IDX_LSB +: BANK_AW]),
                .wdata(data_in),
                .busy (busy[b]),
                .rdata(rdata[b])
            );
        end
    endgenerate

    // Stage 1 tracks which bank holds captured read data; stage 2 is the output register.
    always_comb begin
        ret_d      = '{v: acc & rd, bank: bank};
        data_out_d = ret_q.v ? rdata[ret_q.bank] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q      <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ret_q      <= ret_d;
            data_out_q <= data_out_d;
            err_q      <= bad;
        end
    end

    assign data_out = data_out_q;
    assign err      = err_q;
endmodule

// File: tb/tb_banked_mem_resp.sv
// tb_banked_mem_resp: directed table-driven checks plus reset and long-busy sequences.
module tb_banked_mem_resp;
    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
        logic [3:0]  busy;
        logic        err;
    } vec_t;

    logic        clk, rst, wr, rd, err, err4;
    logic [15:0] addr, data_in, data_out, data_out4;
    logic [3:0]  busy, busy4;
    int          n_chk, n_fail;
    vec_t        v[32];

    banked_mem_resp dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out), .busy(busy), .err(err)
    );

    banked_mem_resp #(.BANK_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
        .data_out(data_out4), .busy(busy4), .err(err4)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input logic r, input logic [15:0] a,
                                input logic [15:0] d, input logic [15:0] o,
                                input logic [3:0] bz, input logic e);
        vec_t t;
        t.wr = w; t.rd = r; t.addr = a; t.din = d; t.dout = o; t.busy = bz; t.err = e;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clk = 0; rst = 0; wr = 0; rd = 0; addr = 0; data_in = 0;
        // Row i: inputs driven in cycle i, outputs expected in cycle i.
        v[0]  = mk(1, 0, 16'h0008, 16'hBEEF, 16'h0000, 4'b0000, 0);
        v[1]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0);
        v[2]  = mk(0, 1, 16'h0008, 16'h0000, 16'h0000, 4'b0000, 0);
        v[3]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 0);
        v[4]  = mk(0, 0, 16'h0000, 16'h0000, 16'hBEEF, 4'b0000, 0);
        v[5]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);
        v[6]  = mk(1, 0, 16'h0100, 16'h1111, 16'h0000, 4'b0000, 0);
        v[7]  = mk(1, 0, 16'h0102, 16'h2222, 16'h0000, 4'b0001, 0);
        v[8]  = mk(1, 0, 16'h0104, 16'h3333, 16'h0000, 4'b0010, 0);
        v[9]  = mk(1, 0, 16'h0106, 16'h4444, 16'h0000, 4'b0100, 0);
        v[10] = mk(0, 1, 16'h0100, 16'h0000, 16'h0000, 4'b1000, 0);
        v[11] = mk(0, 1, 16'h0102, 16'h0000, 16'h0000, 4'b0001, 0);
        v[12] = mk(0, 1, 16'h0104, 16'h0000, 16'h1111, 4'b0010, 0);
        v[13] = mk(0, 1, 16'h0106, 16'h0000, 16'h2222, 4'b0100, 0);
        v[14] = mk(0, 0, 16'h0000, 16'h0000, 16'h3333, 4'b1000, 0);
        v[15] = mk(0, 0, 16'h0000, 16'h0000, 16'h4444, 4'b0000, 0);
        v[16] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);
        v[17] = mk(0, 1, 16'h0102, 16'h0000, 16'h0000, 4'b0000, 0);
        v[18] = mk(1, 0, 16'h0102, 16'hAAAA, 16'h0000, 4'b0010, 0);
        v[19] = mk(0, 0, 16'h0000, 16'h0000, 16'h2222, 4'b0000, 0);
        v[20] = mk(0, 1, 16'h0102, 16'h0000, 16'h0000, 4'b0000, 0);
        v[21] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0010, 0);
        v[22] = mk(0, 0, 16'h0000, 16'h0000, 16'h2222, 4'b0000, 0);
        v[23] = mk(1, 1, 16'h0004, 16'h5A5A, 16'h0000, 4'b0000, 0);
        v[24] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1);
        v[25] = mk(0, 1, 16'h0003, 16'h0000, 16'h0000, 4'b0000, 0);
        v[26] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1);
        v[27] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);
        v[28] = mk(0, 1, 16'h0104, 16'h0000, 16'h0000, 4'b0000, 0);
        v[29] = mk(1, 1, 16'h0104, 16'h0000, 16'h0000, 4'b0100, 0);
        v[30] = mk(0, 0, 16'h0000, 16'h0000, 16'h3333, 4'b0000, 1);
        v[31] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0);

        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("rst busy", {12'h0, busy}, 16'h0000);
        chk("rst err", {15'h0, err}, 16'h0000);
        chk("rst data_out", data_out, 16'h0000);
        chk("rst busy4", {12'h0, busy4}, 16'h0000);
        rst = 0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d data_out", i), data_out, v[i].dout);
            chk($sformatf("row%0d busy", i), {12'h0, busy}, {12'h0, v[i].busy});
            chk($sformatf("row%0d err", i), {15'h0, err}, {15'h0, v[i].err});
            wr = v[i].wr; rd = v[i].rd; addr = v[i].addr; data_in = v[i].din;
        end

        // Reset mid-read: read of 1111 accepted, reset lands before its return.
        @(negedge clk);
        rd = 1; addr = 16'h0100;
        @(negedge clk);
        rd = 0;
        chk("midrst busy before", {12'h0, busy}, 16'h0001);
        #2 rst = 1;
        #1;
        chk("midrst busy async", {12'h0, busy}, 16'h0000);
        chk("midrst data_out async", data_out, 16'h0000);
        @(negedge clk);
        chk("midrst data_out T+2", data_out, 16'h0000);
        rst = 0;
        @(negedge clk);
        chk("midrst data_out T+3", data_out, 16'h0000);

        // BANK_CYCLES=4 instance: bank 2 busy T+1..T+3, retry at T+3 ignored, T+4 accepted.
        @(negedge clk);
        wr = 1; addr = 16'h0004; data_in = 16'h5555;
        @(negedge clk);
        wr = 0;
        chk("bc4 busy T+1", {15'h0, busy4[2]}, 16'h0001);
        @(negedge clk);
        chk("bc4 busy T+2", {15'h0, busy4[2]}, 16'h0001);
        @(negedge clk);
        chk("bc4 busy T+3", {15'h0, busy4[2]}, 16'h0001);
        rd = 1; addr = 16'h0004;
        @(negedge clk);
        chk("bc4 busy T+4", {15'h0, busy4[2]}, 16'h0000);
        @(negedge clk);
        rd = 0;
        chk("bc4 busy T+5", {15'h0, busy4[2]}, 16'h0001);
        chk("bc4 no early return", data_out4, 16'h0000);
        @(negedge clk);
        chk("bc4 data_out", data_out4, 16'h5555);
        @(negedge clk);
        chk("bc4 data_out after", data_out4, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
